// File: rtl/gpu_pkg.sv
// gpu_pkg: core-state encodings shared by the scheduler, register file, ALU,
// LSU and fetcher, plus a small decode helper.
// The REQUEST (3'b011) and UPDATE (3'b110) codes are fixed because the
// register file decodes them directly.
package gpu_pkg;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  // True while the fetcher should be asked for an instruction.
  function automatic logic is_fetch_state(input logic [2:0] state);
    return (state == CORE_FETCH);
  endfunction

endpackage

// File: rtl/core_scheduler_wait_timer.sv
// sched_wait_timer: counts cycles spent in the WAIT state.
// Ports:
//   clock    - rising-edge clock
//   reset    - asynchronous active-low reset
//   clear    - synchronous clear to 0; has priority over count_en
//   count_en - advance the count by one
//   expired  - count has reached WAIT_TIMEOUT-1 (the last allowed WAIT cycle)
// The count saturates at WAIT_TIMEOUT-1, so it can never wrap and
// re-arm the timeout on its own.
module sched_wait_timer #(
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [15:0] LAST_COUNT = 16'(WAIT_TIMEOUT - 1);

  logic [15:0] count_q;
  logic [15:0] count_d;

  // Next-count logic: clear, saturating increment, or hold.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 16'd0;
    end else if (count_en && (count_q != LAST_COUNT)) begin
      count_d = count_q + 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= 16'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/core_scheduler.sv
// core_scheduler: per-core instruction sequencer.
// Walks each instruction through FETCH, DECODE, REQUEST, WAIT, EXECUTE and
// UPDATE, owns the block PC, and flags block completion or an LSU hang.
// Ports:
//   clock, reset       - rising-edge clock, asynchronous active-low reset
//   enable             - 0 freezes state, PC, wait counter, done and error
//   start              - level launch request (sampled in IDLE and DONE only)
//   instruction_ready  - fetcher holds a valid instruction for current_pc
//   decoded_ret        - current instruction is RET
//   decoded_mem_op     - current instruction is LDR/STR
//   lsu_busy           - per-thread LSU outstanding flags
//   next_pc            - PC computed by thread 0
//   core_state         - registered 3-bit state broadcast to the datapath
//   current_pc         - registered PC of the instruction in flight
//   fetch_request      - high while core_state is FETCH (combinational decode)
//   done, error        - registered block-finished and sticky LSU-timeout flags
module core_scheduler
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS      = 4,
  parameter int unsigned PC_WIDTH     = 8,
  parameter int unsigned WAIT_TIMEOUT = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                start,
  input  logic                instruction_ready,
  input  logic                decoded_ret,
  input  logic                decoded_mem_op,
  input  logic [THREADS-1:0]  lsu_busy,
  input  logic [PC_WIDTH-1:0] next_pc,
  output logic [2:0]          core_state,
  output logic [PC_WIDTH-1:0] current_pc,
  output logic                fetch_request,
  output logic                done,
  output logic                error
);

  logic [2:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic timer_clear;
  logic timer_count;
  logic timer_expired;

  // The counter is cleared during REQUEST so the first WAIT cycle sees 0,
  // and only advances in WAIT; both are gated by enable so a frozen core
  // keeps its count.
  assign timer_clear = enable && (state_q == CORE_REQUEST);
  assign timer_count = enable && (state_q == CORE_WAIT);

  sched_wait_timer #(
    .WAIT_TIMEOUT (WAIT_TIMEOUT)
  ) u_wait_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .count_en (timer_count),
    .expired  (timer_expired)
  );

  // Next-state, PC and flag logic for the instruction sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    done_d  = done_q;
    error_d = error_q;
    if (enable) begin
      case (state_q)
        CORE_IDLE: begin
          if (start) begin
            state_d = CORE_FETCH;
            pc_d    = '0;
            done_d  = 1'b0;
            error_d = 1'b0;
          end else begin
            state_d = CORE_IDLE;
          end
        end
        CORE_FETCH: begin
          if (instruction_ready) begin
            state_d = CORE_DECODE;
          end else begin
            state_d = CORE_FETCH;
          end
        end
        CORE_DECODE:  state_d = CORE_REQUEST;
        CORE_REQUEST: state_d = CORE_WAIT;
        CORE_WAIT: begin
          // Non-memory ops ignore lsu_busy and leave after one cycle.
          if (!decoded_mem_op || (lsu_busy == '0)) begin
            state_d = CORE_EXECUTE;
          end else if (timer_expired) begin
            // LSU hang: abort the block, skipping write-back.
            state_d = CORE_DONE;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else begin
            state_d = CORE_WAIT;
          end
        end
        CORE_EXECUTE: state_d = CORE_UPDATE;
        CORE_UPDATE: begin
          if (decoded_ret) begin
            state_d = CORE_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = CORE_FETCH;
            pc_d    = next_pc;
          end
        end
        CORE_DONE: begin
          // A relaunch needs start to drop first, so only its absence is tested.
          if (!start) begin
            state_d = CORE_IDLE;
          end else begin
            state_d = CORE_DONE;
          end
        end
        default: begin
          state_d = CORE_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
      pc_d    = pc_q;
      done_d  = done_q;
      error_d = error_q;
    end
  end

  // Scheduler registers with asynchronous reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= CORE_IDLE;
      pc_q    <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign core_state    = state_q;
  assign current_pc    = pc_q;
  assign done          = done_q;
  assign error         = error_q;
  assign fetch_request = is_fetch_state(state_q);

endmodule

// File: tb/tb_core_scheduler.sv
// Testbench for core_scheduler. An instruction-level model expands each
// block (program, fetch delays, LSU busy lengths, random freezes) into a
// per-cycle list of inputs and expected outputs, which is then played
// against the DUT.
module tb_core_scheduler;

  localparam int TO = 8;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;

  logic       clock = 1'b0;
  logic       reset, enable, start, instruction_ready, decoded_ret, decoded_mem_op;
  logic [3:0] lsu_busy;
  logic [7:0] next_pc;
  logic [2:0] core_state;
  logic [7:0] current_pc;
  logic       fetch_request, done, error;

  core_scheduler #(.THREADS(4), .PC_WIDTH(8), .WAIT_TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .enable(enable), .start(start),
    .instruction_ready(instruction_ready), .decoded_ret(decoded_ret),
    .decoded_mem_op(decoded_mem_op), .lsu_busy(lsu_busy), .next_pc(next_pc),
    .core_state(core_state), .current_pc(current_pc), .fetch_request(fetch_request),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       en, st, rdy, ret, mem;
    logic [3:0] busy;
    logic [7:0] npc;
    logic [2:0] s;
    logic [7:0] pc;
    logic       dn, er;
  } cyc_t;

  cyc_t q[$];
  int compared = 0;
  int mismatched = 0;

  // Program description: per-PC successor, mem flag, busy length, fetch delay.
  logic [7:0] pnxt [256];
  logic       pmem [256];
  int         pbusy[256];
  int         pfd  [256];
  logic [3:0] bpat;
  int         freeze_pct;

  // Model's last expected outputs (used for frozen cycles).
  logic [2:0] ms;
  logic [7:0] mpc;
  logic       mdn, mer;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  task automatic init_prog();
    for (int i = 0; i < 256; i++) begin
      pnxt[i] = 8'(i + 1); pmem[i] = 1'b0; pbusy[i] = 0; pfd[i] = 0;
    end
    bpat = 4'b0101;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic [2:0] s, input logic [7:0] pc, input logic dn, input logic er);
    chk("core_state", {5'd0, core_state}, {5'd0, s});
    chk("current_pc", current_pc, pc);
    chk("done", {7'd0, done}, {7'd0, dn});
    chk("error", {7'd0, error}, {7'd0, er});
    chk("fetch_request", {7'd0, fetch_request}, {7'd0, (s == S_FETCH)});
  endtask

  // Append one enabled cycle, optionally preceded by random frozen cycles.
  task automatic push(input logic st, input logic rdy, input logic ret, input logic mem,
                      input logic [3:0] busy, input logic [7:0] npc,
                      input logic [2:0] s, input logic [7:0] pc, input logic dn, input logic er);
    cyc_t c;
    for (int k = 0; k < 3 && $urandom_range(99, 0) < freeze_pct; k++) begin
      c.en = 1'b0; c.st = rb(); c.rdy = rb(); c.ret = rb(); c.mem = rb();
      c.busy = 4'($urandom); c.npc = 8'($urandom);
      c.s = ms; c.pc = mpc; c.dn = mdn; c.er = mer;
      q.push_back(c);
    end
    c.en = 1'b1; c.st = st; c.rdy = rdy; c.ret = ret; c.mem = mem;
    c.busy = busy; c.npc = npc; c.s = s; c.pc = pc; c.dn = dn; c.er = er;
    q.push_back(c);
    ms = s; mpc = pc; mdn = dn; mer = er;
  endtask

  // Expand one block launched from IDLE; the n_instr-th instruction is RET.
  task automatic gen_block(input int n_instr);
    logic [7:0] pc;
    logic       isret, mem, tmo;
    logic [3:0] b;
    pc = 8'h00;
    push(1'b1, rb(), rb(), rb(), 4'($urandom), 8'($urandom), S_FETCH, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < n_instr; i++) begin
      isret = (i == n_instr - 1);
      mem   = pmem[pc];
      for (int d = 0; d <= pfd[pc]; d++)
        push(rb(), (d == pfd[pc]), rb(), rb(), 4'($urandom), 8'($urandom),
             (d == pfd[pc]) ? S_DECODE : S_FETCH, pc, 1'b0, 1'b0);
      push(rb(), rb(), isret, mem, 4'($urandom), 8'($urandom), S_REQUEST, pc, 1'b0, 1'b0);
      push(rb(), rb(), isret, mem, 4'($urandom), 8'($urandom), S_WAIT, pc, 1'b0, 1'b0);
      tmo = 1'b0;
      for (int w = 0; w < 1000; w++) begin
        b = mem ? ((w < pbusy[pc]) ? bpat : 4'd0) : 4'($urandom);
        if (!mem || b == 4'd0) begin
          push(rb(), rb(), isret, mem, b, 8'($urandom), S_EXECUTE, pc, 1'b0, 1'b0);
          break;
        end else if (w == TO - 1) begin
          push(rb(), rb(), isret, mem, b, 8'($urandom), S_DONE, pc, 1'b1, 1'b1);
          tmo = 1'b1;
          break;
        end else begin
          push(rb(), rb(), isret, mem, b, 8'($urandom), S_WAIT, pc, 1'b0, 1'b0);
        end
      end
      if (tmo) return;
      push(rb(), rb(), isret, mem, 4'($urandom), 8'($urandom), S_UPDATE, pc, 1'b0, 1'b0);
      if (isret) begin
        push(rb(), rb(), 1'b1, mem, 4'($urandom), pnxt[pc], S_DONE, pc, 1'b1, 1'b0);
        return;
      end
      push(rb(), rb(), 1'b0, mem, 4'($urandom), pnxt[pc], S_FETCH, pnxt[pc], 1'b0, 1'b0);
      pc = pnxt[pc];
    end
  endtask

  // Hold start high in DONE for `hold` cycles, then drop it to return to IDLE.
  task automatic gen_done(input int hold);
    for (int h = 0; h < hold; h++)
      push(1'b1, rb(), rb(), rb(), 4'($urandom), 8'($urandom), S_DONE, mpc, mdn, mer);
    push(1'b0, rb(), rb(), rb(), 4'($urandom), 8'($urandom), S_IDLE, mpc, mdn, mer);
  endtask

  // Play the queued cycles; if abort_pc >= 0, pulse reset once EXECUTE at that PC is reached.
  task automatic run_queue(input int abort_pc);
    cyc_t c;
    while (q.size() > 0) begin
      c = q.pop_front();
      enable = c.en; start = c.st; instruction_ready = c.rdy; decoded_ret = c.ret;
      decoded_mem_op = c.mem; lsu_busy = c.busy; next_pc = c.npc;
      @(posedge clock);
      #1;
      check_outputs(c.s, c.pc, c.dn, c.er);
      if (abort_pc >= 0 && c.s == S_EXECUTE && c.pc == 8'(abort_pc)) begin
        #2 reset = 1'b0;
        #1 check_outputs(S_IDLE, 8'h00, 1'b0, 1'b0);
        @(posedge clock);
        #1 check_outputs(S_IDLE, 8'h00, 1'b0, 1'b0);
        reset = 1'b1;
        q.delete();
        ms = S_IDLE; mpc = 8'h00; mdn = 1'b0; mer = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b1; start = 1'b0; instruction_ready = 1'b0;
    decoded_ret = 1'b0; decoded_mem_op = 1'b0; lsu_busy = 4'd0; next_pc = 8'd0;
    ms = S_IDLE; mpc = 8'h00; mdn = 1'b0; mer = 1'b0;
    freeze_pct = 0;
    init_prog();
    repeat (2) @(posedge clock);
    #1 check_outputs(S_IDLE, 8'h00, 1'b0, 1'b0);
    reset = 1'b1;

    // Four plain instructions, RET at pc 3.
    gen_block(4); gen_done(0); run_queue(-1);

    // LDR at pc 0 with LSU busy for the first four WAIT cycles.
    init_prog(); pmem[0] = 1'b1; pbusy[0] = 4; bpat = 4'b0101;
    gen_block(2); gen_done(0); run_queue(-1);

    // LSU stuck busy: timeout after TO WAIT cycles; start held in DONE.
    init_prog(); pmem[0] = 1'b1; pbusy[0] = 1000; bpat = 4'b1000;
    gen_block(3); gen_done(3); run_queue(-1);

    // Heavy freezing across FETCH and WAIT, including a timeout.
    freeze_pct = 50;
    init_prog(); pmem[0] = 1'b1; pbusy[0] = 3; pfd[1] = 2; pmem[1] = 1'b1; pbusy[1] = 1000;
    gen_block(3); gen_done(1); run_queue(-1);
    init_prog(); pmem[0] = 1'b1; pbusy[0] = 5; pfd[0] = 3;
    gen_block(2); gen_done(1); run_queue(-1);
    freeze_pct = 0;

    // Reset mid-EXECUTE at pc 2A, then a full block with start held in DONE.
    init_prog(); pnxt[0] = 8'h2A;
    gen_block(5); run_queue(8'h2A);
    init_prog();
    gen_block(2); gen_done(3); run_queue(-1);

    // PC wrap FF -> 00 and a 10-cycle fetch stall at FF.
    init_prog(); pnxt[0] = 8'hFF; pnxt[8'hFF] = 8'h00; pfd[8'hFF] = 10;
    gen_block(3); gen_done(0); run_queue(-1);

    // Randomised blocks.
    for (int r = 0; r < 8; r++) begin
      init_prog();
      freeze_pct = 20;
      bpat = 4'($urandom_range(15, 1));
      for (int i = 0; i < 256; i++) begin
        pnxt[i]  = 8'($urandom);
        pmem[i]  = rb();
        pbusy[i] = $urandom_range(9, 0);
        pfd[i]   = $urandom_range(3, 0);
      end
      gen_block($urandom_range(6, 1));
      gen_done($urandom_range(2, 0));
      run_queue(-1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
